// File: rtl/adder3_complex_sched.sv
// -----------------------------------------------------------------------------
// adder3_complex_sched
//
// Streaming controller that gathers complex Q(QI.QF) samples into groups of
// three and sums each group on one shared three-operand complex adder. A group
// that s_last closes early is zero-padded. The registered sum is offered on a
// valid/ready output stream. A saturating counter tracks how many emitted
// groups overflowed.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready      input sample handshake
//   s_re, s_im           input sample, signed Q(QI.QF), W bits each
//   s_last               sample closes the current group early
//   m_valid/m_ready      result handshake
//   m_re, m_im           registered group sums, signed, OW bits each
//   m_overflow           adder overflow flag for this group
//   m_count              real (non-padded) samples in the group, 1..3
//   ovf_clr              synchronous clear of ovf_cnt
//   ovf_cnt              saturating count of emitted overflowed groups
//   busy                 high whenever a group is in progress
// -----------------------------------------------------------------------------

// Purely combinational three-operand complex adder. The sums keep full
// precision: two guard bits are enough for three W-bit operands.
module adder3_complex #(
    parameter int QI = 4,
    parameter int QF = 4
) (
    input  logic [QI+QF-1:0] a_re,
    input  logic [QI+QF-1:0] a_im,
    input  logic [QI+QF-1:0] b_re,
    input  logic [QI+QF-1:0] b_im,
    input  logic [QI+QF-1:0] c_re,
    input  logic [QI+QF-1:0] c_im,
    output logic [QI+QF+1:0] d_re,
    output logic [QI+QF+1:0] d_im,
    output logic             overflow
);
    localparam int W  = QI + QF;
    localparam int OW = QI + QF + 2;

    logic ovf_re;
    logic ovf_im;

    // Sign-extend each operand by the two guard bits before adding.
    always_comb begin
        d_re = {{2{a_re[W-1]}}, a_re} + {{2{b_re[W-1]}}, b_re} + {{2{c_re[W-1]}}, c_re};
        d_im = {{2{a_im[W-1]}}, a_im} + {{2{b_im[W-1]}}, b_im} + {{2{c_im[W-1]}}, c_im};
    end

    // A sum fits the signed W-bit range only if its top three bits are all
    // copies of one sign bit.
    always_comb begin
        ovf_re   = !((d_re[OW-1:W-1] == 3'b000) || (d_re[OW-1:W-1] == 3'b111));
        ovf_im   = !((d_im[OW-1:W-1] == 3'b000) || (d_im[OW-1:W-1] == 3'b111));
        overflow = ovf_re || ovf_im;
    end
endmodule

module adder3_complex_sched #(
    parameter int QI = 4,
    parameter int QF = 4,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [QI+QF-1:0] s_re,
    input  logic [QI+QF-1:0] s_im,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [QI+QF+1:0] m_re,
    output logic [QI+QF+1:0] m_im,
    output logic             m_overflow,
    output logic [1:0]       m_count,
    input  logic             ovf_clr,
    output logic [CW-1:0]    ovf_cnt,
    output logic             busy
);
    localparam int W  = QI + QF;
    localparam int OW = QI + QF + 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SUM     = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    idx;
    logic [1:0]    cnt;
    logic [W-1:0]  slot0_re, slot0_im;
    logic [W-1:0]  slot1_re, slot1_im;
    logic [W-1:0]  slot2_re, slot2_im;
    logic [OW-1:0] d_re;
    logic [OW-1:0] d_im;
    logic          overflow;
    logic          accept;
    logic          close_grp;
    logic          out_done;
    logic          ovf_inc;

    adder3_complex #(.QI(QI), .QF(QF)) u_adder (
        .a_re     (slot0_re),
        .a_im     (slot0_im),
        .b_re     (slot1_re),
        .b_im     (slot1_im),
        .c_re     (slot2_re),
        .c_im     (slot2_im),
        .d_re     (d_re),
        .d_im     (d_im),
        .overflow (overflow)
    );

    // A group closes on its third sample or on any sample marked s_last.
    always_comb begin
        accept    = s_valid && s_ready;
        close_grp = accept && ((idx == 2'd2) || s_last);
        out_done  = (state == OUT) && m_ready;
        ovf_inc   = (state == SUM) && overflow;
        busy      = (state != COLLECT) || (idx != 2'd0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Input is accepted only while collecting.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = 1'b1;
                if (close_grp) begin
                    state_nxt = SUM;
                end
            end
            SUM: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    // Slot capture and index tracking. Slots are cleared when a result leaves,
    // so any slot the next group does not write is added in as zero padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 2'd0;
            cnt      <= 2'd0;
            slot0_re <= '0;
            slot0_im <= '0;
            slot1_re <= '0;
            slot1_im <= '0;
            slot2_re <= '0;
            slot2_im <= '0;
        end else if (out_done) begin
            slot0_re <= '0;
            slot0_im <= '0;
            slot1_re <= '0;
            slot1_im <= '0;
            slot2_re <= '0;
            slot2_im <= '0;
        end else if (accept) begin
            case (idx)
                2'd0: begin
                    slot0_re <= s_re;
                    slot0_im <= s_im;
                end
                2'd1: begin
                    slot1_re <= s_re;
                    slot1_im <= s_im;
                end
                default: begin
                    slot2_re <= s_re;
                    slot2_im <= s_im;
                end
            endcase
            if (close_grp) begin
                cnt <= idx + 2'd1;
                idx <= 2'd0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Output register. It loads at the end of the single SUM cycle and holds
    // until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_re       <= '0;
            m_im       <= '0;
            m_overflow <= 1'b0;
            m_count    <= 2'd0;
        end else if (state == SUM) begin
            m_valid    <= 1'b1;
            m_re       <= d_re;
            m_im       <= d_im;
            m_overflow <= overflow;
            m_count    <= cnt;
        end else if (out_done) begin
            m_valid    <= 1'b0;
        end
    end

    // Overflow counter. A clear that coincides with an increment leaves one
    // count: the clear happens first, then the new overflow is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= ovf_inc ? CW'(1) : '0;
        end else if (ovf_inc && (ovf_cnt != {CW{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_adder3_complex_sched.sv
// -----------------------------------------------------------------------------
// tb_adder3_complex_sched
//
// Directed bench for adder3_complex_sched. A transaction-level model (sample
// queue, pending group, presented group, overflow count) predicts the outputs
// every cycle. Literal hand-computed values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_adder3_complex_sched;
    localparam int QI = 4;
    localparam int QF = 4;
    localparam int W  = QI + QF;
    localparam int OW = W + 2;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_re;
    logic [W-1:0]  s_im;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_re;
    logic [OW-1:0] m_im;
    logic          m_overflow;
    logic [1:0]    m_count;
    logic          ovf_clr;
    logic [CW-1:0] ovf_cnt;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    adder3_complex_sched #(.QI(QI), .QF(QF), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_overflow (m_overflow),
        .m_count    (m_count),
        .ovf_clr    (ovf_clr),
        .ovf_cnt    (ovf_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int re;
        int im;
        bit ovf;
        int cnt;
    } grp_t;

    int   smp_re[$];
    int   smp_im[$];
    grp_t pend_grp;
    grp_t cur_grp;
    bit   pend;
    bit   exp_m_valid;
    bit   exp_s_ready;
    int   exp_ovf;

    function automatic grp_t sumGroup();
        grp_t g;
        int   lim;
        g.re  = 0;
        g.im  = 0;
        g.cnt = smp_re.size();
        foreach (smp_re[i]) begin
            g.re += smp_re[i];
            g.im += smp_im[i];
        end
        lim   = 1 << (W - 1);
        g.ovf = (g.re >= lim) || (g.re < -lim) || (g.im >= lim) || (g.im < -lim);
        return g;
    endfunction

    // Each negedge: compare the DUT to the model. Then advance the model to
    // the next rising edge using the inputs now driven.
    initial begin
        bit acc;
        bit inc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                smp_re.delete();
                smp_im.delete();
                pend        = 0;
                exp_m_valid = 0;
                exp_s_ready = 1;
                exp_ovf     = 0;
                cur_grp     = '{re: 0, im: 0, ovf: 0, cnt: 0};
            end
            if (rst_n) begin
                checkOutput("model_s_ready", s_ready, exp_s_ready);
            end
            checkOutput("model_m_valid", m_valid, exp_m_valid);
            checkOutput("model_busy", busy, (!exp_s_ready || smp_re.size() != 0) && rst_n);
            checkOutput("model_ovf_cnt", ovf_cnt, exp_ovf);
            if (exp_m_valid || !rst_n) begin
                checkOutput("model_m_re", $signed(m_re), cur_grp.re);
                checkOutput("model_m_im", $signed(m_im), cur_grp.im);
                checkOutput("model_m_overflow", m_overflow, cur_grp.ovf);
                checkOutput("model_m_count", m_count, cur_grp.cnt);
            end
            if (rst_n) begin
                acc = exp_s_ready && s_valid;
                inc = 0;
                if (exp_m_valid) begin
                    if (m_ready) begin
                        exp_m_valid = 0;
                        exp_s_ready = 1;
                    end
                end else if (pend) begin
                    exp_m_valid = 1;
                    cur_grp     = pend_grp;
                    pend        = 0;
                    inc         = cur_grp.ovf;
                end
                if (ovf_clr) begin
                    exp_ovf = inc ? 1 : 0;
                end else if (inc && exp_ovf < (1 << CW) - 1) begin
                    exp_ovf++;
                end
                if (acc) begin
                    smp_re.push_back($signed(s_re));
                    smp_im.push_back($signed(s_im));
                    if (smp_re.size() == 3 || s_last) begin
                        pend_grp    = sumGroup();
                        pend        = 1;
                        exp_s_ready = 0;
                        smp_re.delete();
                        smp_im.delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one sample and hold it until accepted. Called just after a
    // rising edge; returns just after the accepting edge. waits counts edges.
    task automatic applyStimulus(input int re, input int im, input bit last, output int waits);
        bit acc;
        acc     = 0;
        waits   = 0;
        s_valid = 1'b1;
        s_re    = W'(re);
        s_im    = W'(im);
        s_last  = last;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_re    = '0;
        s_im    = '0;
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic sendGroup(input int re0, input int im0, input int re1, input int im1,
                             input int re2, input int im2);
        int w;
        applyStimulus(re0, im0, 1'b0, w);
        applyStimulus(re1, im1, 1'b0, w);
        applyStimulus(re2, im2, 1'b0, w);
    endtask

    // Wait (bounded) for m_valid, and return at that negedge.
    task automatic waitResult();
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_valid) found = 1;
        end
        checkOutput("result_timeout", found, 1);
    endtask

    task automatic toEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_ovf_cnt", ovf_cnt, 0);
        toEdge();
        rst_n = 1'b1;
        toEdge();

        $display("[TB] full group");
        sendGroup(9, 3, 1, 6, 4, 3);
        @(negedge clk);
        checkOutput("lat_sum_m_valid", m_valid, 0);
        @(negedge clk);
        checkOutput("lat_out_m_valid", m_valid, 1);
        checkOutput("full_m_re", $signed(m_re), 14);
        checkOutput("full_m_im", $signed(m_im), 12);
        checkOutput("full_m_overflow", m_overflow, 0);
        checkOutput("full_m_count", m_count, 3);
        toEdge();

        $display("[TB] negative group");
        sendGroup(-3, -2, 1, 1, -1, -1);
        waitResult();
        checkOutput("neg_m_re_raw", m_re, 10'h3FD);
        checkOutput("neg_m_im_raw", m_im, 10'h3FE);
        checkOutput("neg_m_overflow", m_overflow, 0);
        checkOutput("neg_ovf_cnt", ovf_cnt, 0);
        toEdge();

        $display("[TB] early flush");
        applyStimulus(16, -16, 1'b0, w);
        applyStimulus(16, 16, 1'b1, w);
        waitResult();
        checkOutput("flush_m_re", $signed(m_re), 32);
        checkOutput("flush_m_im", $signed(m_im), 0);
        checkOutput("flush_m_count", m_count, 2);
        toEdge();
        sendGroup(1, 1, 1, 1, 1, 1);
        waitResult();
        checkOutput("after_flush_m_re", $signed(m_re), 3);
        checkOutput("after_flush_m_count", m_count, 3);
        toEdge();

        $display("[TB] backpressure");
        m_ready = 1'b0;
        sendGroup(2, 3, 4, 5, 6, 7);
        waitResult();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_m_valid", m_valid, 1);
            checkOutput("bp_m_re", $signed(m_re), 12);
            checkOutput("bp_m_im", $signed(m_im), 15);
            checkOutput("bp_s_ready", s_ready, 0);
            @(negedge clk);
        end
        toEdge();
        m_ready = 1'b1;
        applyStimulus(1, 0, 1'b1, w);
        checkOutput("bp_accept_edges", w, 2);
        waitResult();
        checkOutput("single_m_re", $signed(m_re), 1);
        checkOutput("single_m_count", m_count, 1);
        toEdge();

        $display("[TB] overflow counter");
        sendGroup(127, 0, 127, 0, 127, 0);
        waitResult();
        checkOutput("ovf_m_re", $signed(m_re), 381);
        checkOutput("ovf_m_overflow", m_overflow, 1);
        checkOutput("ovf_cnt_1", ovf_cnt, 1);
        toEdge();
        sendGroup(-128, -128, -128, -128, -128, -128);
        waitResult();
        checkOutput("ovf_neg_m_re", $signed(m_re), -384);
        checkOutput("ovf_cnt_2", ovf_cnt, 2);
        toEdge();
        ovf_clr = 1'b1;
        toEdge();
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovf_clr_alone", ovf_cnt, 0);
        toEdge();
        sendGroup(127, 0, 127, 0, 127, 0);
        waitResult();
        checkOutput("ovf_cnt_again", ovf_cnt, 1);
        toEdge();
        sendGroup(127, 127, 127, 127, 127, 127);
        ovf_clr = 1'b1;
        toEdge();
        ovf_clr = 1'b0;
        waitResult();
        checkOutput("ovf_clr_coincident", ovf_cnt, 1);
        checkOutput("ovf_coinc_m_im", $signed(m_im), 381);
        toEdge();

        $display("[TB] reset mid-group");
        applyStimulus(50, 50, 1'b0, w);
        applyStimulus(50, 50, 1'b0, w);
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_m_valid", m_valid, 0);
        checkOutput("async_reset_m_re", m_re, 0);
        checkOutput("async_reset_ovf_cnt", ovf_cnt, 0);
        toEdge();
        rst_n = 1'b1;
        toEdge();
        sendGroup(1, 2, 3, 4, 5, 6);
        waitResult();
        checkOutput("post_reset_m_re", $signed(m_re), 9);
        checkOutput("post_reset_m_im", $signed(m_im), 12);
        checkOutput("post_reset_m_count", m_count, 3);
        toEdge();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
